// File: rtl/framebuf_pkg.sv
// Shared frame-buffer geometry and the scanout FSM state encoding.
// Used by the RAM wrapper, the writer side and the LED scanout.
package framebuf_pkg;

    localparam int FB_ADDR_W = 12;
    localparam int FB_DATA_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_CAPTURE,
        ST_SHIFT,
        ST_LATCH
    } scan_state_t;

endpackage

// File: rtl/led_bit_serializer.sv
// Shifts one loaded word MSB-first onto led_sdo with a divided shift clock.
// done is high in the final cycle of bit 0's high phase.
module led_bit_serializer #(
    parameter int DATA_W   = 16,
    parameter int SCLK_DIV = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] din,
    output logic              led_sdo,
    output logic              led_sclk,
    output logic              done
);

    localparam int CNT_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    logic              active;
    logic [CNT_W-1:0]  phase_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shift_reg;
    logic              phase_end;

    assign phase_end = active && (phase_cnt == CNT_LAST);
    assign done      = phase_end && led_sclk && (bit_cnt == '0);
    // Gated by active so the pin idles low after reset without resetting the data register.
    assign led_sdo   = active & shift_reg[DATA_W-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            active    <= 1'b0;
            led_sclk  <= 1'b0;
            phase_cnt <= '0;
            bit_cnt   <= '0;
        end else if (load) begin
            active    <= 1'b1;
            led_sclk  <= 1'b0;
            phase_cnt <= '0;
            bit_cnt   <= BIT_LAST;
        end else if (active) begin
            if (phase_end) begin
                phase_cnt <= '0;
                led_sclk  <= ~led_sclk;
                if (led_sclk) begin
                    if (bit_cnt == '0)
                        active <= 1'b0;
                    else
                        bit_cnt <= bit_cnt - 1'b1;
                end
            end else begin
                phase_cnt <= phase_cnt + 1'b1;
            end
        end
    end

    // Shift happens on the high-to-low edge, so data only moves while led_sclk is low.
    always_ff @(posedge clk) begin
        if (load)
            shift_reg <= din;
        else if (phase_end && led_sclk)
            shift_reg <= shift_reg << 1;
    end

endmodule

// File: rtl/framebuf_led_scanout.sv
// Reads the frame buffer line by line and drives the LED constant-current driver chain.
// Fetch/capture/shift per word, then one latch per line; frames loop while enable is high.
module framebuf_led_scanout #(
    parameter int FB_ADDR_W      = framebuf_pkg::FB_ADDR_W,
    parameter int FB_DATA_W      = framebuf_pkg::FB_DATA_W,
    parameter int WORDS_PER_LINE = 16,
    parameter int NUM_LINES      = 256,
    parameter int SCLK_DIV       = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    output logic [FB_ADDR_W-1:0]         fb_address,
    output logic                         fb_chipselect,
    input  logic [FB_DATA_W-1:0]         fb_readdata,
    output logic                         led_sdo,
    output logic                         led_sclk,
    output logic                         led_latch,
    output logic                         led_blank,
    output logic [$clog2(NUM_LINES)-1:0] line_sel,
    output logic                         frame_done,
    output logic                         busy
);

    import framebuf_pkg::*;

    localparam int LINE_W  = $clog2(NUM_LINES);
    localparam int WORD_SH = $clog2(WORDS_PER_LINE);
    localparam int WORD_W  = (WORD_SH > 0) ? WORD_SH : 1;
    localparam int CNT_W   = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(NUM_LINES - 1);
    localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(WORDS_PER_LINE - 1);
    localparam logic [CNT_W-1:0]  LAT_LAST  = CNT_W'(SCLK_DIV - 1);

    scan_state_t       state;
    logic [LINE_W-1:0] line;
    logic [WORD_W-1:0] word;
    logic [CNT_W-1:0]  lat_cnt;
    logic              ser_load;
    logic              ser_done;

    // Line and word fields are simply placed side by side; no adder is involved.
    function automatic logic [FB_ADDR_W-1:0] fb_addr(input logic [LINE_W-1:0] l,
                                                      input logic [WORD_W-1:0] w);
        return (FB_ADDR_W'(l) << WORD_SH) | FB_ADDR_W'(w);
    endfunction

    assign ser_load = (state == ST_CAPTURE);

    led_bit_serializer #(
        .DATA_W   (FB_DATA_W),
        .SCLK_DIV (SCLK_DIV)
    ) u_serializer (
        .clk      (clk),
        .reset    (reset),
        .load     (ser_load),
        .din      (fb_readdata),
        .led_sdo  (led_sdo),
        .led_sclk (led_sclk),
        .done     (ser_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            line          <= '0;
            word          <= '0;
            lat_cnt       <= '0;
            fb_address    <= '0;
            fb_chipselect <= 1'b0;
            led_latch     <= 1'b0;
            led_blank     <= 1'b1;
            line_sel      <= '0;
            frame_done    <= 1'b0;
            busy          <= 1'b0;
        end else begin
            fb_chipselect <= 1'b0;
            frame_done    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        state         <= ST_FETCH;
                        line          <= '0;
                        word          <= '0;
                        fb_address    <= fb_addr('0, '0);
                        fb_chipselect <= 1'b1;
                        busy          <= 1'b1;
                    end
                end
                ST_FETCH:   state <= ST_CAPTURE;
                ST_CAPTURE: state <= ST_SHIFT;
                ST_SHIFT: begin
                    if (ser_done) begin
                        if (word != WORD_LAST) begin
                            word          <= word + 1'b1;
                            fb_address    <= fb_addr(line, word + 1'b1);
                            fb_chipselect <= 1'b1;
                            state         <= ST_FETCH;
                        end else begin
                            lat_cnt   <= '0;
                            led_latch <= 1'b1;
                            led_blank <= 1'b1;
                            state     <= ST_LATCH;
                        end
                    end
                end
                ST_LATCH: begin
                    if (lat_cnt == LAT_LAST) begin
                        led_latch <= 1'b0;
                        led_blank <= 1'b0;
                        line_sel  <= line;
                        word      <= '0;
                        // enable is only honoured at the frame boundary.
                        if (line == LINE_LAST) begin
                            line       <= '0;
                            frame_done <= 1'b1;
                            if (enable) begin
                                fb_address    <= fb_addr('0, '0);
                                fb_chipselect <= 1'b1;
                                state         <= ST_FETCH;
                            end else begin
                                led_blank <= 1'b1;
                                busy      <= 1'b0;
                                state     <= ST_IDLE;
                            end
                        end else begin
                            line          <= line + 1'b1;
                            fb_address    <= fb_addr(line + 1'b1, '0);
                            fb_chipselect <= 1'b1;
                            state         <= ST_FETCH;
                        end
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
